// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// IF stage plus IF/ID pipeline register of the 5-stage word-addressed core.
// Holds the fetch PC, presents it to instruction memory, selects the next PC
// (sequential, decode-stage jump, EX-stage branch) and registers the fetched
// instruction and its PC+1 into decode. Redirects squash the IF/ID slot and
// are tallied in a saturating flush counter.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   stallF      hazard unit request to hold PCF
//   stallD      hazard unit request to hold the IF/ID register
//   PCSrcE      EX-stage branch taken this cycle
//   PCBranchE   EX-stage branch target
//   JumpD       decode-stage instruction is a jump
//   PCJumpD     jump target computed in decode
//   imem_addr   instruction memory address (always equal to PCF)
//   imem_rdata  instruction word at imem_addr, same-cycle read
//   imem_ready  imem_rdata is valid this cycle
//   PCF         current fetch PC
//   InstrD      IF/ID instruction word
//   PCp1D       IF/ID PC+1
//   validD      InstrD holds a real instruction (0 = bubble)
//   flush_cnt   saturating count of IF/ID flush events
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             PCSrcE,
    input  logic [31:0]      PCBranchE,
    input  logic             JumpD,
    input  logic [31:0]      PCJumpD,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCp1D,
    output logic             validD,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] pcp1f;
    logic [31:0] pc_next;
    logic        branch_taken;
    logic        jump_taken;
    logic        redirect;
    logic        cnt_full;

    // Wraps modulo 2^32 by construction; no carry is kept.
    assign pcp1f     = PCF + 32'd1;
    assign imem_addr = PCF;

    // A jump only redirects when decode is actually advancing; a stalled
    // decode slot may still be re-evaluated next cycle.
    assign branch_taken = PCSrcE;
    assign jump_taken   = JumpD & ~stallD;
    // A branch/jump collision is a single redirect, hence a single flush.
    assign redirect     = branch_taken | jump_taken;
    assign cnt_full     = &flush_cnt;

    // Next-PC selection. The branch outranks the jump because the EX-stage
    // instruction is older than the one in decode.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_next = pcp1f;
        if (branch_taken) begin
            pc_next = PCBranchE;
        end else if (jump_taken) begin
            pc_next = PCJumpD;
        end else if (stallF || stallD || !imem_ready) begin
            // stallD without stallF is not expected, but holding PC keeps
            // the fetched instruction from being skipped if it happens.
            pc_next = PCF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pc_next;
        end
    end

    // IF/ID register. imem_rdata only ever feeds this register, so there is
    // no combinational path from memory data to any output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD <= NOP_INSTR;
            PCp1D  <= 32'd0;
            validD <= 1'b0;
        end else if (redirect) begin
            // Squash the wrong-path slot; this wins over stallD.
            InstrD <= NOP_INSTR;
            PCp1D  <= 32'd0;
            validD <= 1'b0;
        end else if (stallD) begin
            InstrD <= InstrD;
            PCp1D  <= PCp1D;
            validD <= validD;
        end else if (!imem_ready) begin
            // Memory not ready: insert a bubble (not a flush event).
            InstrD <= NOP_INSTR;
            PCp1D  <= 32'd0;
            validD <= 1'b0;
        end else begin
            InstrD <= imem_rdata;
            PCp1D  <= pcp1f;
            validD <= 1'b1;
        end
    end

    // Flush event counter, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (redirect && !cnt_full) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. A behavioural model of the fetch PC and
// IF/ID slot is compared against the DUT on every falling edge; literal
// expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] MEM_BASE  = 32'hA000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallF, stallD, PCSrcE, JumpD, imem_ready;
    logic [31:0]      PCBranchE, PCJumpD;
    logic [31:0]      imem_addr, imem_rdata;
    logic [31:0]      PCF, InstrD, PCp1D;
    logic             validD;
    logic [CNT_W-1:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory: word at address a is MEM_BASE + a.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return MEM_BASE + a;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stallF    (stallF),
        .stallD    (stallD),
        .PCSrcE    (PCSrcE),
        .PCBranchE (PCBranchE),
        .JumpD     (JumpD),
        .PCJumpD   (PCJumpD),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCp1D     (PCp1D),
        .validD    (validD),
        .flush_cnt (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pcp1;
    logic        m_valid;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= RESET_PC;
            m_instr <= NOP_INSTR;
            m_pcp1  <= 32'd0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (PCSrcE || (JumpD && !stallD)) begin
            // Redirect: go to target, kill the decode slot, count one flush.
            m_pc    <= PCSrcE ? PCBranchE : PCJumpD;
            m_instr <= NOP_INSTR;
            m_pcp1  <= 32'd0;
            m_valid <= 1'b0;
            m_cnt   <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (stallD) begin
            // Decode frozen: nothing moves.
            m_pc    <= m_pc;
        end else if (!imem_ready) begin
            // Waiting on memory: PC stays, decode receives a bubble.
            m_instr <= NOP_INSTR;
            m_pcp1  <= 32'd0;
            m_valid <= 1'b0;
        end else begin
            // Instruction delivered; PC advances unless fetch is stalled.
            m_instr <= mem(m_pc);
            m_pcp1  <= m_pc + 32'd1;
            m_valid <= 1'b1;
            m_pc    <= stallF ? m_pc : m_pc + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_PCF",       PCF,              m_pc);
            check("cmp_imem_addr", imem_addr,        m_pc);
            check("cmp_InstrD",    InstrD,           m_instr);
            check("cmp_PCp1D",     PCp1D,            m_pcp1);
            check("cmp_validD",    32'(validD),      32'(m_valid));
            check("cmp_flush_cnt", 32'(flush_cnt),   32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs (from a falling edge) and return at the next
    // falling edge, after the rising edge has taken effect.
    task automatic tick(input logic sf, input logic sd, input logic ps, input logic [31:0] pb,
                        input logic jd, input logic [31:0] pj, input logic rdy);
        stallF     = sf;
        stallD     = sd;
        PCSrcE     = ps;
        PCBranchE  = pb;
        JumpD      = jd;
        PCJumpD    = pj;
        imem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic jump(input logic [31:0] t);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, t, 1'b1);
    endtask

    task automatic lit(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] p1, input logic v, input int cnt);
        check({tag, "_PCF"},    PCF,            pc);
        check({tag, "_InstrD"}, InstrD,         ins);
        check({tag, "_PCp1D"},  PCp1D,          p1);
        check({tag, "_validD"}, 32'(validD),    32'(v));
        check({tag, "_cnt"},    32'(flush_cnt), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        stallF = 1'b0; stallD = 1'b0; PCSrcE = 1'b0; JumpD = 1'b0;
        PCBranchE = 32'd0; PCJumpD = 32'd0; imem_ready = 1'b1;
        #1;
        lit("reset", RESET_PC, NOP_INSTR, 32'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from reset.
        idle();
        lit("seq1", 32'd1, 32'hA000_0000, 32'd1, 1'b1, 0);
        idle();
        idle();
        lit("seq3", 32'd3, 32'hA000_0002, 32'd3, 1'b1, 0);
        idle();
        idle();
        check("seq5_PCF", PCF, 32'd5);

        // Branch while both stalls asserted: branch wins.
        tick(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
        lit("br", 32'h40, NOP_INSTR, 32'd0, 1'b0, 1);
        idle();
        lit("br_tgt", 32'h41, 32'hA000_0040, 32'h41, 1'b1, 1);

        // Jump with decode advancing.
        jump(32'h100);
        lit("jmp", 32'h100, NOP_INSTR, 32'd0, 1'b0, 2);
        idle();
        lit("jmp_tgt", 32'h101, 32'hA000_0100, 32'h101, 1'b1, 2);

        // Jump while decode stalled: ignored, everything holds.
        tick(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1);
        lit("jmp_stall", 32'h101, 32'hA000_0100, 32'h101, 1'b1, 2);

        // Illegal stallD without stallF: PC and IF/ID still hold.
        tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        lit("sd_only", 32'h101, 32'hA000_0100, 32'h101, 1'b1, 2);

        // Fetch stall alone: PC holds, decode still loads current PC's word.
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        lit("sf_only", 32'h101, 32'hA000_0101, 32'h102, 1'b1, 2);

        // Memory not ready for 3 cycles at PC 7.
        jump(32'd7);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            lit("nrdy", 32'd7, NOP_INSTR, 32'd0, 1'b0, 3);
        end
        idle();
        lit("rdy_back", 32'd8, 32'hA000_0007, 32'd8, 1'b1, 3);

        // Branch with memory not ready: branch still taken.
        tick(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0);
        lit("br_nrdy", 32'h80, NOP_INSTR, 32'd0, 1'b0, 4);

        // Branch and jump collide: branch target, counted once.
        tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
        lit("collide", 32'h200, NOP_INSTR, 32'd0, 1'b0, 5);

        // PC wrap at all-ones.
        jump(32'hFFFF_FFFF);
        lit("wrap_pre", 32'hFFFF_FFFF, NOP_INSTR, 32'd0, 1'b0, 6);
        idle();
        lit("wrap", 32'd0, 32'h9FFF_FFFF, 32'd0, 1'b1, 6);

        // Counter saturation.
        for (int i = 0; i < 12; i++) jump(32'h10 + 32'(i));
        check("sat_cnt", 32'(flush_cnt), 32'(CNT_MAX));
        tick(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
        check("sat_hold", 32'(flush_cnt), 32'(CNT_MAX));

        // Reset asserted mid-stall, between edges.
        jump(32'h32);
        idle();
        lit("pre_rst", 32'h33, 32'hA000_0032, 32'h33, 1'b1, CNT_MAX);
        tick(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        lit("async_rst", RESET_PC, NOP_INSTR, 32'd0, 1'b0, 0);
        @(negedge clk);
        stallF = 1'b0; stallD = 1'b0; JumpD = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b1;
        rst = 1'b0;
        idle();
        idle();
        lit("post_rst", 32'd2, 32'hA000_0001, 32'd2, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
